// File: rtl/muladd_pkg.sv
// Shared types and defaults for the iterative multiply-accumulate unit.
package muladd_pkg;

    localparam int unsigned MULADD_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        ACC,
        DONE
    } muladd_state_t;

endpackage

// File: rtl/muladd_seq_unit_if.sv
// Pipeline-facing bundle of the multiply-accumulate unit: operands, control, status and result.
interface muladd_seq_unit_if
    import muladd_pkg::*;
#(
    parameter int unsigned WIDTH = MULADD_WIDTH
);

    logic             start;
    logic             flush;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic             stall_req;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, flush, a, b, c,
        input  stall_req, busy, done, result
    );

    modport slave (
        input  start, flush, a, b, c,
        output stall_req, busy, done, result
    );

endinterface

// File: rtl/muladd_shift_acc.sv
// Shift-add datapath: holds multiplicand, multiplier and partial product, one iteration per step.
module muladd_shift_acc
    import muladd_pkg::*;
#(
    parameter int unsigned WIDTH = MULADD_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] mcand_i,
    input  logic [WIDTH-1:0] mult_i,
    output logic [WIDTH-1:0] prod_o,
    output logic             last_o
);

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mult_q,  mult_d;
    logic [WIDTH-1:0] prod_q,  prod_d;

    always_comb begin
        mcand_d = mcand_q;
        mult_d  = mult_q;
        prod_d  = prod_q;
        if (load_i) begin
            mcand_d = mcand_i;
            mult_d  = mult_i;
            prod_d  = '0;
        end else if (step_i) begin
            if (mult_q[0]) begin
                prod_d = prod_q + mcand_q;
            end
            mcand_d = mcand_q << 1;
            mult_d  = mult_q >> 1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcand_q <= '0;
            mult_q  <= '0;
            prod_q  <= '0;
        end else begin
            mcand_q <= mcand_d;
            mult_q  <= mult_d;
            prod_q  <= prod_d;
        end
    end

    assign prod_o = prod_q;
    // High when the multiplier will be exhausted after the current step.
    assign last_o = (mult_q[WIDTH-1:1] == '0);

endmodule

// File: rtl/muladd_seq_unit.sv
// Multi-cycle result = b*c + a (low WIDTH bits) for EX; raises stall_req while an op is in flight.
module muladd_seq_unit
    import muladd_pkg::*;
#(
    parameter int unsigned WIDTH = MULADD_WIDTH,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic           clk,
    input  logic           reset_n,
    muladd_seq_unit_if.slave bus
);

    muladd_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] addend_q, addend_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] prod;
    logic             last;
    logic             accept;
    logic             step;

    assign accept = (state_q == IDLE) && bus.start && !bus.flush;

    muladd_shift_acc #(
        .WIDTH(WIDTH)
    ) u_shift_acc (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (accept),
        .step_i  (step),
        .mcand_i (bus.b),
        .mult_i  (bus.c),
        .prod_o  (prod),
        .last_o  (last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = (bus.c != '0) ? MUL : ACC;
            MUL:     if (last || (cnt_q == CNT_W'(WIDTH - 1))) state_d = ACC;
            ACC:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.flush) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        step          = (state_q == MUL);
        bus.busy      = (state_q == MUL) || (state_q == ACC);
        bus.stall_req = bus.busy || accept;
        bus.done      = (state_q == DONE);
    end

    always_comb begin
        cnt_d    = cnt_q;
        addend_d = addend_q;
        result_d = result_q;
        if (accept) begin
            cnt_d    = '0;
            addend_d = bus.a;
        end else if (state_q == MUL) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // A flush landing in ACC must leave the previously completed result visible.
        if ((state_q == ACC) && !bus.flush) begin
            result_d = prod + addend_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            addend_q <= '0;
            result_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            addend_q <= addend_d;
            result_q <= result_d;
        end
    end

    assign bus.result = result_q;

endmodule

// File: tb/tb_muladd_seq_unit.sv
// Scoreboard bench for muladd_seq_unit: directed operations, flush, reset and back-to-back cases.
module tb_muladd_seq_unit;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t sb_q[$];

    muladd_seq_unit_if #(.WIDTH(32)) bus ();

    muladd_seq_unit #(
        .WIDTH(32)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every done pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && bus.done) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: done=1 with nothing pending (cycle %0d)", cyc);
            end else begin
                e = sb_q.pop_front();
                check("result", bus.result, e.res);
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    // Single start pulse; checks stall_req/busy in every cycle until the unit is back in IDLE.
    task automatic run_op(input logic [31:0] a_v, input logic [31:0] b_v, input logic [31:0] c_v,
                          input int k, input logic [31:0] exp);
        bus.start = 1'b1;
        bus.a     = a_v;
        bus.b     = b_v;
        bus.c     = c_v;
        sb_q.push_back('{exp, cyc + k + 2});
        for (int i = 0; i <= k + 2; i++) begin
            @(negedge clk);
            check("stall_req", 32'(bus.stall_req), 32'(i < k + 2));
            check("busy", 32'(bus.busy), 32'((i >= 1) && (i <= k + 1)));
            tick();
            if (i == 0) bus.start = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.c     = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_result", bus.result, 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_stall", 32'(bus.stall_req), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        run_op(32'd5, 32'd3, 32'd4, 3, 32'd17);
        run_op(32'd9, 32'd123, 32'd0, 0, 32'd9);
        run_op(32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 32'd1);
        run_op(32'd1, 32'h8000_0000, 32'd2, 2, 32'd1);
        run_op(32'h10, 32'h1234, 32'hF0, 8, 32'h0011_10D0);

        // Flush in cycle 3 of an operation.
        bus.start = 1'b1;
        bus.a = 32'd0;
        bus.b = 32'd6;
        bus.c = 32'h80;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        bus.flush = 1'b1;
        @(negedge clk);
        check("flush_busy_before", 32'(bus.busy), 32'd1);
        tick();
        bus.flush = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("flush_busy_after", 32'(bus.busy), 32'd0);
            tick();
        end
        check("flush_result_kept", bus.result, 32'h0011_10D0);

        // flush and start together in IDLE.
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.a = 32'd1;
        bus.b = 32'd1;
        bus.c = 32'd1;
        @(negedge clk);
        check("flush_start_stall", 32'(bus.stall_req), 32'd0);
        tick();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("flush_start_busy", 32'(bus.busy), 32'd0);
            tick();
        end
        check("flush_start_result", bus.result, 32'h0011_10D0);

        // Back-to-back: start held through op1; operands change while op1 runs.
        bus.start = 1'b1;
        bus.a = 32'd1;
        bus.b = 32'd2;
        bus.c = 32'd3;
        sb_q.push_back('{32'd7, cyc + 4});
        sb_q.push_back('{32'd105, cyc + 8});
        for (int i = 0; i <= 8; i++) begin
            if (i == 1) begin
                bus.a = 32'd100;
                bus.b = 32'd5;
                bus.c = 32'd1;
            end
            if (i == 6) bus.start = 1'b0;
            @(negedge clk);
            check("b2b_stall", 32'(bus.stall_req), 32'((i != 4) && (i != 8)));
            check("b2b_busy", 32'(bus.busy), 32'((i >= 1 && i <= 3) || (i >= 6 && i <= 7)));
            tick();
        end

        // Asynchronous reset in the middle of MUL.
        bus.start = 1'b1;
        bus.a = 32'd0;
        bus.b = 32'd7;
        bus.c = 32'hFF;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        check("mid_busy", 32'(bus.busy), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_rst_result", bus.result, 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_stall", 32'(bus.stall_req), 32'd0);
        check("mid_rst_done", 32'(bus.done), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("post_rst_busy", 32'(bus.busy), 32'd0);
            tick();
        end

        tick();
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
